// File: rtl/uart_img_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_img_pkg : shared codes, byte-FSM states and frame length for    |
// | the UART image loader (UART_IMG_CHECKSUM_EN adds a 9th byte).        |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package uart_img_pkg;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_FRAME   = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;
   localparam logic [1:0] ERR_CSUM    = 2'b11;

`ifdef UART_IMG_CHECKSUM_EN
   localparam int unsigned FRAME_BYTES = 9;
`else
   localparam int unsigned FRAME_BYTES = 8;
`endif

   typedef enum logic [2:0] {
      RX_IDLE  = 3'd0,
      RX_START = 3'd1,
      RX_DATA  = 3'd2,
      RX_STOP  = 3'd3,
      RX_BREAK = 3'd4
   } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_rx_byte : 8N1 receiver with 2-FF synchroniser, oversampling     |
// | tick divider and mid-bit sampling byte FSM.                          |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module uart_rx_byte
   import uart_img_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 100_000_000,
   parameter int unsigned BAUD       = 115_200,
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] byte_out,
   output logic       byte_valid,
   output logic       frame_err
);

   localparam int unsigned DIV   = CLK_HZ / (BAUD * OVERSAMPLE);
   localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned OS_W  = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
   localparam logic [OS_W-1:0]  OS_MID   = OS_W'(OVERSAMPLE / 2 - 1);
   localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);

   logic             rx_meta_q, rx_sync_q, rx_prev_q;
   logic [DIV_W-1:0] div_q;
   rx_state_e        state_q, state_d;
   logic [OS_W-1:0]  os_q, os_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             valid_q, valid_d;
   logic             ferr_q, ferr_d;
   logic             w_tick, w_fall;

   assign w_tick = (div_q == DIV_LAST);
   assign w_fall = rx_prev_q & ~rx_sync_q;

   always_comb begin
      state_d = state_q;
      os_d    = w_tick ? os_q + OS_W'(1) : os_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         RX_IDLE: begin
            os_d  = '0;
            bit_d = '0;
            if (w_fall) state_d = RX_START;
         end
         RX_START: begin
            // A start bit that is high again at mid-bit was a glitch.
            if (w_tick && os_q == OS_MID) begin
               os_d    = '0;
               state_d = rx_sync_q ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (w_tick && os_q == OS_LAST) begin
               os_d    = '0;
               shift_d = {rx_sync_q, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = RX_STOP;
            end
         end
         RX_STOP: begin
            if (w_tick && os_q == OS_LAST) begin
               os_d = '0;
               if (rx_sync_q) begin
                  valid_d = 1'b1;
                  state_d = RX_IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = RX_BREAK;
               end
            end
         end
         RX_BREAK: begin
            if (rx_sync_q) state_d = RX_IDLE;
         end
         default: state_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         rx_prev_q <= 1'b1;
         div_q     <= '0;
         state_q   <= RX_IDLE;
         os_q      <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         rx_meta_q <= rx;
         rx_sync_q <= rx_meta_q;
         rx_prev_q <= rx_sync_q;
         div_q     <= w_tick ? '0 : div_q + DIV_W'(1);
         state_q   <= state_d;
         os_q      <= os_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
      end
   end

   assign byte_out   = shift_q;
   assign byte_valid = valid_q;
   assign frame_err  = ferr_q;

endmodule
`default_nettype wire

// File: rtl/uart_image_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_image_loader : assembles UART bytes into an 8x8 image with      |
// | timeout; UART_IMG_CHECKSUM_EN enables a trailing XOR byte check.     |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module uart_image_loader
   import uart_img_pkg::*;
#(
   parameter int unsigned CLK_HZ       = 100_000_000,
   parameter int unsigned BAUD         = 115_200,
   parameter int unsigned OVERSAMPLE   = 16,
   parameter int unsigned TIMEOUT_CLKS = 1_000_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rx,
   output logic [63:0] im_out,
   output logic        im_valid,
   output logic        err,
   output logic [1:0]  err_code,
   output logic        busy
);

   localparam int unsigned TO_W = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CLKS - 1);
   localparam logic [3:0]      LAST_IDX = 4'(FRAME_BYTES - 1);

   logic [7:0]      byte_out;
   logic            byte_valid, frame_err;
   logic [3:0]      cnt_q, cnt_d;
   logic [63:0]     shadow_q, shadow_d;
   logic [63:0]     im_q, im_d;
   logic [TO_W-1:0] idle_q, idle_d;
   logic            valid_q, valid_d, err_q, err_d;
   logic [1:0]      code_q, code_d;
   logic            commit_q, commit_d, cerr_q, cerr_d;
   logic            w_last, w_timeout, w_csum_ok;

   uart_rx_byte #(
      .CLK_HZ     (CLK_HZ),
      .BAUD       (BAUD),
      .OVERSAMPLE (OVERSAMPLE)
   ) u_rx (
      .clk        (clk),
      .reset      (reset),
      .rx         (rx),
      .byte_out   (byte_out),
      .byte_valid (byte_valid),
      .frame_err  (frame_err)
   );

   assign busy      = (cnt_q != 4'd0);
   assign w_last    = byte_valid && (cnt_q == LAST_IDX);
   assign w_timeout = busy && (idle_q == TO_LAST);

`ifdef UART_IMG_CHECKSUM_EN
   logic [7:0] csum_q;
   always_ff @(posedge clk) begin
      if (reset || frame_err || w_last || (w_timeout && !byte_valid))
         csum_q <= '0;
      else if (byte_valid)
         csum_q <= csum_q ^ byte_out;
   end
   assign w_csum_ok = (byte_out == csum_q);
`else
   assign w_csum_ok = 1'b1;
`endif

   always_comb begin
      cnt_d    = cnt_q;
      shadow_d = shadow_q;
      im_d     = im_q;
      idle_d   = '0;
      valid_d  = 1'b0;
      err_d    = 1'b0;
      code_d   = ERR_NONE;
      commit_d = 1'b0;
      cerr_d   = 1'b0;
      // Commit lags the last byte by one clk so im_out only ever sees whole frames.
      if (commit_q) begin
         im_d    = shadow_q;
         valid_d = 1'b1;
      end
      if (cerr_q) begin
         err_d  = 1'b1;
         code_d = ERR_CSUM;
      end
      if (frame_err) begin
         cnt_d  = '0;
         err_d  = 1'b1;
         code_d = ERR_FRAME;
      end else if (byte_valid) begin
         if (!cnt_q[3]) shadow_d[{cnt_q[2:0], 3'b000} +: 8] = byte_out;
         if (w_last) begin
            cnt_d    = '0;
            commit_d = w_csum_ok;
            cerr_d   = !w_csum_ok;
         end else begin
            cnt_d = cnt_q + 4'd1;
         end
      end else if (busy) begin
         if (w_timeout) begin
            cnt_d  = '0;
            err_d  = 1'b1;
            code_d = ERR_TIMEOUT;
         end else begin
            idle_d = idle_q + TO_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q    <= '0;
         shadow_q <= '0;
         im_q     <= '0;
         idle_q   <= '0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
         code_q   <= ERR_NONE;
         commit_q <= 1'b0;
         cerr_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         im_q     <= im_d;
         idle_q   <= idle_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
         code_q   <= code_d;
         commit_q <= commit_d;
         cerr_q   <= cerr_d;
      end
   end

   assign im_out   = im_q;
   assign im_valid = valid_q;
   assign err      = err_q;
   assign err_code = code_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_image_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_image_loader : directed self-checking bench for the UART     |
// | image loader (also covers UART_IMG_CHECKSUM_EN when defined).        |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_uart_image_loader;

   // DIV = 3_200_000 / (100_000*16) = 2, so one bit lasts 32 clks.
   localparam int unsigned CLK_HZ  = 3_200_000;
   localparam int unsigned BAUD    = 100_000;
   localparam int unsigned OS      = 16;
   localparam int unsigned TIMEOUT = 1000;
   localparam int unsigned BIT     = 32;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        rx = 1'b1;
   logic [63:0] im_out;
   logic        im_valid, err, busy;
   logic [1:0]  err_code;

   int n_tests = 0;
   int n_fail  = 0;
   int n_valid = 0;
   int n_err   = 0;
   int n_bad   = 0;
   logic [1:0]  last_code = 2'b00;
   logic [63:0] prev_im = '0;
   int v0, e0;

   always #5 clk = ~clk;

   uart_image_loader #(
      .CLK_HZ       (CLK_HZ),
      .BAUD         (BAUD),
      .OVERSAMPLE   (OS),
      .TIMEOUT_CLKS (TIMEOUT)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .rx       (rx),
      .im_out   (im_out),
      .im_valid (im_valid),
      .err      (err),
      .err_code (err_code),
      .busy     (busy)
   );

   always @(negedge clk) begin
      if (im_valid) n_valid <= n_valid + 1;
      if (err) begin
         n_err     <= n_err + 1;
         last_code <= err_code;
      end
      // im_out may only move on an im_valid pulse or back to zero on reset.
      if (im_out !== prev_im && !im_valid && im_out !== 64'd0) n_bad <= n_bad + 1;
      prev_im <= im_out;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      rx = 1'b0;
      repeat (BIT) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (BIT) @(negedge clk);
      end
      rx = stop_bit;
      repeat (BIT) @(negedge clk);
   endtask

   task automatic send_frame(input logic [63:0] img);
      logic [7:0] x;
      x = 8'h00;
      for (int k = 0; k < 8; k++) begin
         send_byte(img[8*k +: 8], 1'b1);
         x = x ^ img[8*k +: 8];
      end
`ifdef UART_IMG_CHECKSUM_EN
      send_byte(x, 1'b1);
`endif
   endtask

   task automatic snap();
      v0 = n_valid;
      e0 = n_err;
   endtask

   initial begin
      repeat (5) @(negedge clk);
      check("rst_im_out",   im_out,   64'd0);
      check("rst_im_valid", 64'(im_valid), 64'd0);
      check("rst_err",      64'(err),      64'd0);
      check("rst_err_code", 64'(err_code), 64'd0);
      check("rst_busy",     64'(busy),     64'd0);
      reset = 1'b0;
      repeat (3 * BIT) @(negedge clk);

      // Basic frame: one walking bit per row.
      snap();
      send_frame(64'h8040201008040201);
      repeat (4) @(negedge clk);
      check("t1_im_out",  im_out, 64'h8040201008040201);
      check("t1_valids",  64'(n_valid - v0), 64'd1);
      check("t1_errs",    64'(n_err - e0),   64'd0);
      check("t1_busy",    64'(busy),         64'd0);

      // Partial frame followed by a long idle gap.
      snap();
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      send_byte(8'h33, 1'b1);
      check("t2_busy_mid", 64'(busy), 64'd1);
      repeat (TIMEOUT + 100) @(negedge clk);
      check("t2_errs",   64'(n_err - e0),   64'd1);
      check("t2_code",   64'(last_code),    64'(2'b10));
      check("t2_busy",   64'(busy),         64'd0);
      check("t2_im_out", im_out, 64'h8040201008040201);
      check("t2_valids", 64'(n_valid - v0), 64'd0);
      snap();
      send_frame(64'h8796A5B4C3D2E1F0);
      repeat (4) @(negedge clk);
      check("t2_reload", im_out, 64'h8796A5B4C3D2E1F0);
      check("t2_reload_valids", 64'(n_valid - v0), 64'd1);

      // Stop bit of byte 4 held low, line stays low for several bit times.
      snap();
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      send_byte(8'h33, 1'b1);
      send_byte(8'h44, 1'b1);
      send_byte(8'h55, 1'b0);
      repeat (4 * BIT) @(negedge clk);
      rx = 1'b1;
      repeat (2 * BIT) @(negedge clk);
      check("t3_errs",   64'(n_err - e0),   64'd1);
      check("t3_code",   64'(last_code),    64'(2'b01));
      check("t3_busy",   64'(busy),         64'd0);
      check("t3_valids", 64'(n_valid - v0), 64'd0);
      check("t3_im_out", im_out, 64'h8796A5B4C3D2E1F0);
      send_frame(64'hF0DEBC9A78563412);
      repeat (4) @(negedge clk);
      check("t3_reload", im_out, 64'hF0DEBC9A78563412);

      // Short low glitch, well under half a bit.
      snap();
      rx = 1'b0;
      repeat (8) @(negedge clk);
      rx = 1'b1;
      repeat (3 * BIT) @(negedge clk);
      check("t4_valids", 64'(n_valid - v0), 64'd0);
      check("t4_errs",   64'(n_err - e0),   64'd0);
      check("t4_busy",   64'(busy),         64'd0);
      send_frame(64'h0123456789ABCDEF);
      repeat (4) @(negedge clk);
      check("t4_reload", im_out, 64'h0123456789ABCDEF);

      // Reset in the middle of byte 6.
      for (int k = 0; k < 6; k++) send_byte(8'hFF, 1'b1);
      rx = 1'b0;
      repeat (BIT) @(negedge clk);
      rx = 1'b1;
      repeat (3 * BIT) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("t5_rst_im_out", im_out,     64'd0);
      check("t5_rst_busy",   64'(busy),  64'd0);
      reset = 1'b0;
      repeat (2 * BIT) @(negedge clk);
      snap();
      send_frame(64'hFFFFFFFFFFFFFFFF);
      repeat (4) @(negedge clk);
      check("t5_im_out", im_out, 64'hFFFFFFFFFFFFFFFF);
      check("t5_valids", 64'(n_valid - v0), 64'd1);

`ifdef UART_IMG_CHECKSUM_EN
      snap();
      for (int k = 0; k < 8; k++) send_byte(8'hAA, 1'b1);
      send_byte(8'h00, 1'b1);
      repeat (4) @(negedge clk);
      check("t6_ok_valids", 64'(n_valid - v0), 64'd1);
      check("t6_ok_im_out", im_out, 64'hAAAAAAAAAAAAAAAA);
      snap();
      for (int k = 0; k < 8; k++) send_byte(8'h55, 1'b1);
      send_byte(8'h01, 1'b1);
      repeat (4) @(negedge clk);
      check("t6_bad_valids", 64'(n_valid - v0), 64'd0);
      check("t6_bad_errs",   64'(n_err - e0),   64'd1);
      check("t6_bad_code",   64'(last_code),    64'(2'b11));
      check("t6_bad_im_out", im_out, 64'hAAAAAAAAAAAAAAAA);
`endif

      // Two frames back to back with no idle gap.
      snap();
      send_frame(64'h1111111111111111);
      send_frame(64'h0F0E0D0C0B0A0908);
      repeat (4) @(negedge clk);
      check("t7_valids", 64'(n_valid - v0), 64'd2);
      check("t7_errs",   64'(n_err - e0),   64'd0);
      check("t7_im_out", im_out, 64'h0F0E0D0C0B0A0908);

      check("no_partial_update", 64'(n_bad), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
